// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard and two registered read ports.
// Reads are write-first: a same-cycle write or scoreboard update is visible on the read.
module regfile_sb #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 8,
   parameter int ZERO_R0 = 0,
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re_a,
   input  logic [AW-1:0]    raddr_a,
   input  logic             re_b,
   input  logic [AW-1:0]    raddr_b,
   input  logic             bset,
   input  logic [AW-1:0]    bset_addr,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b,
   output logic             busy_a,
   output logic             busy_b
);

   // Storage covers the full address space; slots at or above DEPTH (and r0 when
   // hardwired) are never written, so they stay zero and reads of them return zero.
   localparam int          NREG    = 1 << AW;
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem      [NREG];
   logic [WIDTH-1:0] mem_nxt  [NREG];
   logic [NREG-1:0]  busy;
   logic [NREG-1:0]  busy_nxt;

   function automatic logic addr_ok(input logic [AW-1:0] addr);
      return ({1'b0, addr} < DEPTH_W) && !((ZERO_R0 != 0) && (addr == '0));
   endfunction

   // Post-edge view of the array and scoreboard; reads sample this for write-first bypass.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' with every output defaulted first,
      // so later statements see earlier updates and no latch is inferred.
      mem_nxt  = mem;
      busy_nxt = busy;
      if (we && addr_ok(waddr)) begin
         mem_nxt[waddr]  = wdata;
         busy_nxt[waddr] = 1'b0;
      end
      // Applied after the write so a same-cycle set wins over the write's clear.
      if (bset && addr_ok(bset_addr)) begin
         busy_nxt[bset_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking '<='; the storage array is reset
      // here as well because every register must read back zero after reset.
      if (reset) begin
         mem     <= '{default: '0};
         busy    <= '0;
         rdata_a <= '0;
         rdata_b <= '0;
         busy_a  <= 1'b0;
         busy_b  <= 1'b0;
      end else begin
         mem  <= mem_nxt;
         busy <= busy_nxt;
         if (re_a) begin
            rdata_a <= mem_nxt[raddr_a];
            busy_a  <= busy_nxt[raddr_a];
         end
         if (re_b) begin
            rdata_b <= mem_nxt[raddr_b];
            busy_b  <= busy_nxt[raddr_b];
         end
      end
   end

endmodule
